// File: rtl/bcd_converter_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock,
// with start/busy/done handshake, overflow flag and leading-zero blanking mask.
module bcd_converter_seq #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     lz_mask
);

    localparam int SR_W = 4*DIGITS + BIN_W;
    localparam int IT_W = $clog2(BIN_W + 1);

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t               state_q;
    logic [SR_W-1:0]      sr_q;
    logic [IT_W-1:0]      iter_q;
    logic                 ovf_acc_q;
    logic                 busy_q;
    logic                 done_q;
    logic [4*DIGITS-1:0]  bcd_q;
    logic                 ovf_q;
    logic [DIGITS-1:0]    lz_q;

    logic [SR_W-1:0]      adj_d;
    logic [SR_W-1:0]      sr_d;
    logic                 ovf_acc_d;
    logic [4*DIGITS-1:0]  bcd_d;
    logic [DIGITS-1:0]    lz_d;
    logic                 zero_run;

    always_comb begin
        adj_d = sr_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (adj_d[BIN_W+4*i +: 4] >= 4'd5)
                adj_d[BIN_W+4*i +: 4] = adj_d[BIN_W+4*i +: 4] + 4'd3;
        end
        sr_d      = {adj_d[SR_W-2:0], 1'b0};
        // Any bit leaving the top digit means the value needs more than DIGITS digits.
        ovf_acc_d = ovf_acc_q | adj_d[SR_W-1];
        bcd_d     = sr_d[SR_W-1:BIN_W];

        lz_d     = '0;
        zero_run = 1'b1;
        for (int unsigned k = 0; k < DIGITS-1; k++) begin
            zero_run = zero_run & (bcd_d[4*(DIGITS-1-k) +: 4] == 4'd0);
            lz_d[DIGITS-1-k] = zero_run;
        end
        if (ovf_acc_d)
            lz_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            iter_q    <= '0;
            ovf_acc_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            lz_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sr_q      <= SR_W'(bin_in);
                        iter_q    <= '0;
                        ovf_acc_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q      <= sr_d;
                    ovf_acc_q <= ovf_acc_d;
                    iter_q    <= iter_q + IT_W'(1);
                    if (iter_q == IT_W'(BIN_W-1)) begin
                        bcd_q   <= bcd_d;
                        ovf_q   <= ovf_acc_d;
                        lz_q    <= lz_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;
    assign lz_mask  = lz_q;

endmodule
